dnn_fc_layer_fix: RTL and testbench
===================================

Name: dnn_fc_layer_fix

Overview:
Parametrised fixed-point fully-connected layer engine for the MNIST inference datapath. It is generalised in input count, output count, word width, Q-format and post-scale. It streams activations and weights from one synchronous single-port memory and performs MAC accumulation. Each output then gets bias, a runtime-selectable ReLU and saturation. It also provides a running argmax class index and a saturation flag, so that layers chain into an N-layer network or feed the classifier directly.

Parameters:
DATA_WIDTH, 15, signed word width of activations, weights, biases and outputs
FRAC_BITS, 13, fractional bits (Q1.13 at default; 1.0 = 8192)
ADDR_WIDTH, 17, memory address width
N_IN, 400, inputs per neuron
N_OUT, 10, neurons (outputs)
ADDR_BASE_A, 'h0000, base address of activation vector
ADDR_BASE_W, 'h0191, base address of weight matrix
POST_SHIFT, 0, extra arithmetic right shift applied after requantisation (layer scale)

Ports:
clk  in  1  clock
rst  in  1  reset; active-low, synchronous
start  in  1  pulse; begin layer computation (sampled in IDLE or DONE)
clear  in  1  synchronous soft clear to IDLE; outputs zeroed
relu_en  in  1  1 = apply ReLU; sampled at start and held for the run
mem_data  in  DATA_WIDTH signed  read data; valid one cycle after mem_addr
mem_addr  out  ADDR_WIDTH  registered read address
busy  out  1  high from the cycle after start until done rises
done  out  1  level; high after the last writeback until the next start or clear
out[N_OUT-1:0]  out  DATA_WIDTH signed each  layer results
class_idx  out  $clog2(N_OUT)  index of max out; ties resolve to the lowest index
sat  out  1  sticky per run; any output saturated

Behaviour:
- Reset (rst=0 at clk edge) and clear: state=IDLE, mem_addr=0, busy=0, done=0, sat=0, class_idx=0, all out=0. Reset or clear mid-run aborts immediately, with no partial writeback. clear takes priority over start.
- Memory layout:
  - activation i at ADDR_BASE_A+i
  - weight (j,i) at ADDR_BASE_W + j*(N_IN+1) + i
  - bias j at ADDR_BASE_W + j*(N_IN+1) + N_IN
- States and timing:
  - IDLE/DONE --start--> RUN.
  - Per neuron j there are 2*N_IN+3 cycles:
    - 2*N_IN+1 address cycles issuing a0,w(j,0),a1,w(j,1),...,a(N_IN-1),w(j,N_IN-1),b(j)
    - 1 cycle for the last data return
    - 1 WB cycle
  - Next neuron begins the cycle after WB. After WB of neuron N_OUT-1: state=DONE, done=1, busy=0.
  - done rises exactly N_OUT*(2*N_IN+3)+1 cycles after the cycle in which start is sampled.
- start while RUN is ignored. start in DONE restarts the run:
  - done drops the next cycle
  - sat is cleared
  - out and class_idx keep their old values until overwritten by each WB
- Arithmetic:
  - Returned activation is latched. Returned weight is multiplied with the latched activation as a 2*DATA_WIDTH signed product.
  - Accumulator width is ACC_WIDTH = 2*DATA_WIDTH+$clog2(N_IN+2) (localparam), so overflow is impossible.
  - Bias is sign-extended and added as bias<<<FRAC_BITS.
  - Accumulator clears at the start of each neuron.
- WB requantisation, in order:
  1. r = acc >>> (FRAC_BITS+POST_SHIFT), arithmetic, truncate toward −inf
  2. if relu_en and r<0, then r=0
  3. saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; set sat if clipped
  4. out[j] = r
- Argmax:
  - At WB of j=0, class_idx=0 and the max register = r.
  - For j>0, class_idx updates only if r > max (strict).
- mem_addr holds its last value in IDLE/DONE.

Decomposition:
- Package dnn_fix_pkg:
  - fsm state enum (IDLE, RUN, WB, DONE)
  - function for ACC_WIDTH computation
  - requant/saturate helper constants (MAX/MIN for DATA_WIDTH)
- One sub-module dnn_fix_requant: combinational shift + ReLU + saturate + sat flag, parametrised by DATA_WIDTH, ACC_WIDTH, SHIFT. It is reused by future layer engines.

Test Plan:
1. N_IN=2, N_OUT=2, relu_en=1; memory contents: a={8192,4096}; row0 w={4096,8192}, b=1000; row1 w={−8192,−8192}, b=0. Required response: out={9192,0}, class_idx=0, sat=0, done 15 cycles after start. Address sequence must be 0,0x191,1,0x192,0x193, then 0,0x194,1,0x195,0x196.
2. Same stimulus with relu_en=0 -> out[1]=−12288, class_idx=0.
3. Saturation: a={16383,0}, w row0={16383,0}, b=0 -> out[0]=16383, sat=1. Row weights negated -> out[0]=−16384 with relu_en=0, and 0 with relu_en=1.
4. Tie and argmax: biases only (a=0), b={500,700,700} with N_OUT=3 -> class_idx=1.
5. Abort: clear asserted mid-run (cycle 5) -> next cycle busy=0, done=0, all out=0. start pulsed during RUN is ignored, and the done timing of the original run is unchanged.
6. Reset and restart: rst=0 for one cycle in DONE -> all outputs return to reset values. start in DONE -> done drops the next cycle, and the rerun gives identical results.

Source files
------------

// File: rtl/dnn_fix_pkg.sv
// Shared types and sizing helpers for the fixed-point layer engines.
// Pure declarations: no timing, no flow control.
package dnn_fix_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WB, DONE} fsm_state_t;

    // Tags what the word on mem_data is, one cycle after its address went out.
    typedef enum logic [1:0] {RD_NONE, RD_ACT, RD_WGT, RD_BIAS} rd_kind_t;

    function automatic int acc_width(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in + 2);
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/dnn_fc_layer_fix_if.sv
// Control, memory-read and result bundle of a fixed-point FC layer engine.
// master = controller/memory side, slave = engine side.
interface dnn_fc_layer_fix_if #(
    parameter int DATA_WIDTH = 15,
    parameter int ADDR_WIDTH = 17,
    parameter int N_OUT      = 10
);
    logic                                start;
    logic                                clear;
    logic                                relu_en;
    logic signed [DATA_WIDTH-1:0]        mem_data;
    logic        [ADDR_WIDTH-1:0]        mem_addr;
    logic                                busy;
    logic                                done;
    logic [N_OUT-1:0][DATA_WIDTH-1:0]    out;
    logic [$clog2(N_OUT)-1:0]            class_idx;
    logic                                sat;

    modport master (
        output start, clear, relu_en, mem_data,
        input  mem_addr, busy, done, out, class_idx, sat
    );

    modport slave (
        input  start, clear, relu_en, mem_data,
        output mem_addr, busy, done, out, class_idx, sat
    );
endinterface

// File: rtl/dnn_fix_requant.sv
// Accumulator to output word: arithmetic shift, optional ReLU, saturation with clip flag.
// Purely combinational, no flow control.
module dnn_fix_requant
    import dnn_fix_pkg::*;
#(
    parameter int DATA_WIDTH = 15,
    parameter int ACC_WIDTH  = 39,
    parameter int SHIFT      = 13
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] res,
    output logic                         clipped
);
    localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        if (relu_en && shifted[ACC_WIDTH-1]) begin
            shifted = '0;
        end
        clipped = 1'b0;
        res     = shifted[DATA_WIDTH-1:0];
        if (shifted > MAXV) begin
            res     = MAXV[DATA_WIDTH-1:0];
            clipped = 1'b1;
        end else if (shifted < MINV) begin
            res     = MINV[DATA_WIDTH-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/dnn_fc_layer_fix.sv
// Fixed-point FC layer: streams act/weight pairs from one sync memory, MAC, bias, requant, argmax.
// N_OUT*(2*N_IN+3)+1 cycles start-to-done; no backpressure, memory must answer every cycle.
module dnn_fc_layer_fix
    import dnn_fix_pkg::*;
#(
    parameter int          DATA_WIDTH  = 15,
    parameter int          FRAC_BITS   = 13,
    parameter int          ADDR_WIDTH  = 17,
    parameter int          N_IN        = 400,
    parameter int          N_OUT       = 10,
    parameter int unsigned ADDR_BASE_A = 'h0000,
    parameter int unsigned ADDR_BASE_W = 'h0191,
    parameter int          POST_SHIFT  = 0
) (
    input logic               clk,
    input logic               rst,
    dnn_fc_layer_fix_if.slave bus
);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N_IN);
    localparam int KW        = $clog2(2 * N_IN + 2);
    localparam int CW        = $clog2(N_OUT);

    localparam logic [KW-1:0]         LAST_K = KW'(2 * N_IN);
    localparam logic [KW-1:0]         BIAS_K = KW'(2 * N_IN - 1);
    localparam logic [CW-1:0]         LAST_J = CW'(N_OUT - 1);
    localparam logic [ADDR_WIDTH-1:0] A0     = ADDR_WIDTH'(ADDR_BASE_A);
    localparam logic [ADDR_WIDTH-1:0] A1     = ADDR_WIDTH'(ADDR_BASE_A + 1);
    localparam logic [ADDR_WIDTH-1:0] W0     = ADDR_WIDTH'(ADDR_BASE_W);

    fsm_state_t                       state;
    rd_kind_t                         pend;
    logic [KW-1:0]                    k;
    logic [CW-1:0]                    j;
    logic [ADDR_WIDTH-1:0]            mem_addr_q, a_ptr, w_ptr;
    logic signed [DATA_WIDTH-1:0]     act_lat, max_q;
    logic signed [ACC_WIDTH-1:0]      acc;
    logic                             relu_q, busy_q, done_q, sat_q;
    logic [N_OUT-1:0][DATA_WIDTH-1:0] out_q;
    logic [CW-1:0]                    class_q;

    logic signed [2*DATA_WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]      prod_ext, bias_ext;
    logic signed [DATA_WIDTH-1:0]     res;
    logic                             clipped;

    assign prod     = (2*DATA_WIDTH)'(act_lat) * (2*DATA_WIDTH)'(bus.mem_data);
    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'(bus.mem_data) <<< FRAC_BITS;

    dnn_fix_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (FRAC_BITS + POST_SHIFT)
    ) u_requant (
        .acc     (acc),
        .relu_en (relu_q),
        .res     (res),
        .clipped (clipped)
    );

    always_ff @(posedge clk) begin
        if (!rst || bus.clear) begin
            state      <= IDLE;
            pend       <= RD_NONE;
            k          <= '0;
            j          <= '0;
            mem_addr_q <= '0;
            a_ptr      <= '0;
            w_ptr      <= '0;
            act_lat    <= '0;
            max_q      <= '0;
            acc        <= '0;
            relu_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            out_q      <= '0;
            class_q    <= '0;
        end else begin
            case (pend)
                RD_ACT:  act_lat <= bus.mem_data;
                RD_WGT:  acc     <= acc + prod_ext;
                RD_BIAS: acc     <= acc + bias_ext;
                default: ;
            endcase
            pend <= RD_NONE;

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        sat_q      <= 1'b0;
                        relu_q     <= bus.relu_en;
                        k          <= '0;
                        j          <= '0;
                        mem_addr_q <= A0;
                        a_ptr      <= A1;
                        w_ptr      <= W0;
                        acc        <= '0;
                    end
                end
                RUN: begin
                    // Even k: activation on the bus; odd k: weight; LAST_K: bias.
                    // w_ptr walks straight through the row, so after N_IN weights it lands on the bias.
                    if (k < LAST_K) begin
                        k    <= k + 1'b1;
                        pend <= k[0] ? RD_WGT : RD_ACT;
                        if (!k[0] || k == BIAS_K) begin
                            mem_addr_q <= w_ptr;
                            w_ptr      <= w_ptr + 1'b1;
                        end else begin
                            mem_addr_q <= a_ptr;
                            a_ptr      <= a_ptr + 1'b1;
                        end
                    end else if (k == LAST_K) begin
                        k    <= k + 1'b1;
                        pend <= RD_BIAS;
                    end else begin
                        state <= WB;
                    end
                end
                WB: begin
                    out_q[j] <= res;
                    sat_q    <= sat_q | clipped;
                    if (j == '0) begin
                        class_q <= '0;
                        max_q   <= res;
                    end else if (res > max_q) begin
                        class_q <= j;
                        max_q   <= res;
                    end
                    if (j == LAST_J) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state      <= RUN;
                        j          <= j + 1'b1;
                        k          <= '0;
                        mem_addr_q <= A0;
                        a_ptr      <= A1;
                        acc        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out       = out_q;
    assign bus.class_idx = class_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_dnn_fc_layer_fix.sv
// Bench for dnn_fc_layer_fix: memory responder, reference model feeding a scoreboard,
// and a monitor checking addresses each cycle and results at every rising done.
module tb_dnn_fc_layer_fix;
    localparam int DW     = 15;
    localparam int FRAC   = 13;
    localparam int AW     = 17;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 3;
    localparam int POST   = 0;
    localparam int BASE_A = 'h0;
    localparam int BASE_W = 'h191;
    localparam int NPER   = 2 * N_IN + 3;
    localparam longint VMAX = 16383;
    localparam longint VMIN = -16384;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dnn_fc_layer_fix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_OUT(N_OUT)) ifc ();

    dnn_fc_layer_fix #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FRAC),
        .ADDR_WIDTH (AW),
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .ADDR_BASE_A(BASE_A),
        .ADDR_BASE_W(BASE_W),
        .POST_SHIFT (POST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic signed [DW-1:0] mem [0:1023];
    always @(posedge clk) ifc.mem_data <= mem[ifc.mem_addr[9:0]];

    typedef struct packed {
        logic [N_OUT-1:0][DW-1:0] o;
        logic [1:0]               cls;
        logic                     sat;
        int                       done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   addr_q[$];
    int   cyc = 0;
    int   start_cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done_prev = 1'b0;
    int   mon_t, mon_p, mon_a;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Layer computed straight from the memory image with wide integer arithmetic.
    function automatic exp_t model(input bit relu);
        exp_t   e;
        longint acc, r, best;
        e = '0;
        best = 0;
        for (int jj = 0; jj < N_OUT; jj++) begin
            acc = longint'(mem[BASE_W + jj*(N_IN+1) + N_IN]) * (longint'(1) << FRAC);
            for (int ii = 0; ii < N_IN; ii++)
                acc += longint'(mem[BASE_A + ii]) * longint'(mem[BASE_W + jj*(N_IN+1) + ii]);
            r = acc >>> (FRAC + POST);
            if (relu && r < 0) r = 0;
            if (r > VMAX) begin r = VMAX; e.sat = 1'b1; end
            if (r < VMIN) begin r = VMIN; e.sat = 1'b1; end
            e.o[jj] = r[DW-1:0];
            if (jj == 0 || r > best) begin
                best  = r;
                e.cls = 2'(jj);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (ifc.busy) begin
            mon_t = cyc - start_cyc;
            mon_p = (mon_t - 1) % NPER;
            if (mon_p <= 2 * N_IN) begin
                if (addr_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL addr_extra: got %0h with no address expected", ifc.mem_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    chk($sformatf("addr_t%0d", mon_t), longint'(ifc.mem_addr), longint'(mon_a));
                end
            end
        end
        if (ifc.done && !done_prev) begin
            if (sb_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_done: done rose at cycle %0d, required no result", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                for (int jj = 0; jj < N_OUT; jj++)
                    chk($sformatf("out%0d", jj), longint'($signed(ifc.out[jj])),
                        longint'($signed(mon_e.o[jj])));
                chk("class_idx", longint'(ifc.class_idx), longint'(mon_e.cls));
                chk("sat", longint'(ifc.sat), longint'(mon_e.sat));
                chk("done_cycle", longint'(cyc), longint'(mon_e.done_cyc));
                chk("busy_at_done", longint'(ifc.busy), 0);
            end
        end
        done_prev = ifc.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input int jj, input int ii, input int v);
        mem[BASE_W + jj*(N_IN+1) + ii] = DW'(v);
    endtask

    task automatic load(input int a0, input int a1,
                        input int w00, input int w01, input int b0,
                        input int w10, input int w11, input int b1,
                        input int w20, input int w21, input int b2);
        mem[BASE_A]     = DW'(a0);
        mem[BASE_A + 1] = DW'(a1);
        wr_w(0, 0, w00); wr_w(0, 1, w01); wr_w(0, 2, b0);
        wr_w(1, 0, w10); wr_w(1, 1, w11); wr_w(1, 2, b1);
        wr_w(2, 0, w20); wr_w(2, 1, w21); wr_w(2, 2, b2);
    endtask

    task automatic run_start();
        exp_t e;
        ifc.start = 1'b1;
        start_cyc = cyc;
        e = model(ifc.relu_en);
        e.done_cyc = cyc + N_OUT * NPER + 1;
        sb_q.push_back(e);
        for (int jj = 0; jj < N_OUT; jj++) begin
            for (int ii = 0; ii < N_IN; ii++) begin
                addr_q.push_back(BASE_A + ii);
                addr_q.push_back(BASE_W + jj*(N_IN+1) + ii);
            end
            addr_q.push_back(BASE_W + jj*(N_IN+1) + N_IN);
        end
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!ifc.done && n < 200) begin
            tick();
            n++;
        end
        if (!ifc.done) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, n);
        end
        tick();
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, longint'(ifc.busy), 0);
        chk({name, "_done"}, longint'(ifc.done), 0);
        chk({name, "_sat"}, longint'(ifc.sat), 0);
        chk({name, "_class"}, longint'(ifc.class_idx), 0);
        chk({name, "_addr"}, longint'(ifc.mem_addr), 0);
        for (int jj = 0; jj < N_OUT; jj++)
            chk($sformatf("%s_out%0d", name, jj), longint'($signed(ifc.out[jj])), 0);
    endtask

    function automatic int rnd();
        int v;
        v = int'($urandom_range(0, 32767)) - 16384;
        return v >>> $urandom_range(0, 3);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ifc.start   = 1'b0;
        ifc.clear   = 1'b0;
        ifc.relu_en = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_reset_state("reset");

        // Basic layer with ReLU, then without.
        load(8192, 4096, 4096, 8192, 1000, -8192, -8192, 0, 0, 0, 0);
        ifc.relu_en = 1'b1;
        run_start();
        wait_done("t1");
        chk("t1_out0", longint'($signed(ifc.out[0])), 9192);
        chk("t1_out1", longint'($signed(ifc.out[1])), 0);
        chk("t1_class", longint'(ifc.class_idx), 0);

        ifc.relu_en = 1'b0;
        run_start();
        wait_done("t2");
        chk("t2_out1", longint'($signed(ifc.out[1])), -12288);
        chk("t2_class", longint'(ifc.class_idx), 0);

        // Saturation in both directions.
        load(16383, 0, 16383, 0, 0, 0, 0, 0, 0, 0, 0);
        ifc.relu_en = 1'b1;
        run_start();
        wait_done("t3a");
        chk("t3a_out0", longint'($signed(ifc.out[0])), 16383);
        chk("t3a_sat", longint'(ifc.sat), 1);
        wr_w(0, 0, -16383);
        ifc.relu_en = 1'b0;
        run_start();
        wait_done("t3b");
        chk("t3b_out0", longint'($signed(ifc.out[0])), -16384);
        chk("t3b_sat", longint'(ifc.sat), 1);
        ifc.relu_en = 1'b1;
        run_start();
        wait_done("t3c");
        chk("t3c_out0", longint'($signed(ifc.out[0])), 0);
        chk("t3c_sat", longint'(ifc.sat), 0);

        // Tie between neurons 1 and 2 resolves to the lower index.
        load(0, 0, 0, 0, 500, 0, 0, 700, 0, 0, 700);
        run_start();
        wait_done("t4");
        chk("t4_class", longint'(ifc.class_idx), 1);

        // Abort with clear in cycle 5 of a run.
        load(8192, 4096, 4096, 8192, 1000, -8192, -8192, 0, 100, 200, 300);
        run_start();
        repeat (4) tick();
        ifc.clear = 1'b1;
        tick();
        ifc.clear = 1'b0;
        sb_q.delete();
        addr_q.delete();
        chk_reset_state("abort");

        // clear wins over a simultaneous start.
        ifc.start = 1'b1;
        ifc.clear = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.clear = 1'b0;
        chk("clr_prio_busy", longint'(ifc.busy), 0);

        // A start pulse during RUN must not disturb the run.
        run_start();
        tick(); tick();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        wait_done("t5");

        // Reset in DONE, then restart from DONE.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_reset_state("rst_done");
        run_start();
        wait_done("t6a");
        run_start();
        chk("restart_done_drop", longint'(ifc.done), 0);
        chk("restart_busy", longint'(ifc.busy), 1);
        wait_done("t6b");

        // Randomised layers.
        for (int r = 0; r < 10; r++) begin
            load(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
            ifc.relu_en = 1'($urandom_range(0, 1));
            run_start();
            wait_done($sformatf("rand%0d", r));
        end

        repeat (2) tick();
        if (sb_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_leftover: %0d results never seen, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
